tcam_access_arbiter: RTL and testbench
======================================

Name: tcam_access_arbiter

Overview:
- Sequences all accesses to the cache TCAM and shares it between two requesters: per-packet key lookups from the key extractor, and control-plane entry writes (HOT_INSERT/DELETE) from the op4 path.
- Exactly one TCAM operation is outstanding at any time. Lookups have priority; a burst limit prevents write starvation.
- Lookup results return to the cache output scheduler. A timeout guard recovers the block if the TCAM never signals end.

Parameters:
- KEY_WIDTH, 32, key and mask width.
- TCAM_MATCH_ADDR, 10, TCAM entry address width.
- MAX_LKP_BURST, 4, consecutive lookup grants allowed while a write is pending (1..15).
- TIMEOUT_CYCLES, 64, wait-state cycles before an operation is abandoned (2..255).

Ports:
- axis_aclk  in  1  clock.
- axis_reset  in  1  synchronous, active-high reset.
- lkp_valid  in  1  lookup request.
- lkp_ready  out  1  lookup accepted when lkp_valid && lkp_ready.
- lkp_key  in  KEY_WIDTH  lookup key.
- lkp_mask  in  KEY_WIDTH  lookup mask.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  TCAM_MATCH_ADDR  entry to write.
- wr_key  in  KEY_WIDTH  entry key.
- wr_mask  in  KEY_WIDTH  entry mask.
- tcam_req_valid  out  1  one-cycle command strobe to the TCAM.
- tcam_req_wr  out  1  1 = write, 0 = lookup.
- tcam_req_addr  out  TCAM_MATCH_ADDR  write address (0 for lookups).
- tcam_req_key  out  KEY_WIDTH  command key.
- tcam_req_mask  out  KEY_WIDTH  command mask.
- tcam_busy  in  1  TCAM busy.
- tcam_end  in  1  one-cycle completion pulse, for both lookups and writes.
- tcam_match  in  1  lookup hit, valid with tcam_end.
- tcam_match_addr  in  TCAM_MATCH_ADDR  hit address, valid with tcam_end.
- res_valid  out  1  one-cycle lookup result strobe.
- res_match  out  1  hit flag.
- res_addr  out  TCAM_MATCH_ADDR  hit address.
- res_timeout  out  1  result produced by timeout.
- stat_timeout_cnt  out  16  saturating count of timeouts.

Behaviour:
- Reset: state IDLE; all outputs, counters and captured fields are 0. Reset mid-operation discards the outstanding operation. A tcam_end arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT_LKP, WAIT_WR.
- Ready signals are combinational:
  - lkp_ready = IDLE && !tcam_busy && grant_lkp.
  - wr_ready = IDLE && !tcam_busy && !grant_lkp.
- grant_lkp = lkp_valid && !(wr_valid && burst_cnt == MAX_LKP_BURST). If only wr_valid is asserted, the write is granted.
- burst_cnt:
  - Increments on a lookup grant while wr_valid = 1.
  - Clears on a write grant, or in any IDLE cycle with wr_valid = 0.
  - Never exceeds MAX_LKP_BURST.
- IDLE -> ISSUE on an accepted transfer. The key, mask, address and type of the granted request are captured in that cycle.
- ISSUE: tcam_req_valid = 1 for exactly one cycle with the captured fields, then go to WAIT_LKP (lookup) or WAIT_WR (write). At all other times tcam_req_* = 0.
- WAIT_LKP:
  - On tcam_end, the next cycle carries res_valid = 1, res_match = tcam_match, res_addr = tcam_match_addr, res_timeout = 0; state returns to IDLE.
  - Latency: acceptance at cycle T, command at T+1, result at E+1 where E is the tcam_end cycle.
- WAIT_WR: on tcam_end go to IDLE. No res_valid is produced for writes.
- Timeout:
  - wait_cnt clears on ISSUE and increments each wait cycle.
  - When wait_cnt reaches TIMEOUT_CYCLES-1 without tcam_end:
    - Lookup: res_valid = 1, res_match = 0, res_addr = 0, res_timeout = 1.
    - Write: no result.
  - In both cases stat_timeout_cnt increments (saturating at 16'hFFFF) and state returns to IDLE.
  - If tcam_end coincides with expiry, tcam_end wins and no timeout is counted.
- tcam_end in IDLE or ISSUE (late or spurious) is ignored.
- res_* outputs hold 0 except in the res_valid cycle.
- Maximum throughput is one operation per 3 + TCAM latency cycles. No back-pressure on res_valid: the consumer must always accept it.

Test Plan:
- Single lookup, key 32'h0000_1234, mask all-ones; TCAM returns tcam_end at T+4 with match = 1, addr = 10'd17 -> tcam_req_valid only at T+1 with tcam_req_wr = 0; res_valid at T+5 with res_match = 1, res_addr = 17, res_timeout = 0.
- Single write, addr = 5, key 32'hAABB_CCDD; tcam_end after 3 cycles -> one command strobe with tcam_req_wr = 1, addr = 5; no res_valid; wr_ready is 0 until back in IDLE.
- lkp_valid and wr_valid held high continuously, MAX_LKP_BURST = 4 -> grant order L, L, L, L, W, L, L, L, L, W.
- tcam_busy = 1 in IDLE with both requests pending -> lkp_ready = wr_ready = 0 until busy drops; the first grant is the lookup.
- Lookup with no tcam_end, TIMEOUT_CYCLES = 8 -> res_valid with res_match = 0, res_timeout = 1 after 8 wait cycles; stat_timeout_cnt = 1. A later stray tcam_end is ignored, and the next lookup completes normally.
- Reset asserted in WAIT_LKP -> next cycle state is IDLE and every output is 0; the tcam_end for the dropped lookup produces no res_valid.

Source files
------------

// File: rtl/tcam_access_arbiter.sv
// tcam_access_arbiter: shares the cache TCAM between key lookups and entry writes, one operation outstanding
`timescale 1ns/1ps
module tcam_access_arbiter #(
  parameter int KEY_WIDTH = 32,
  parameter int TCAM_MATCH_ADDR = 10,
  parameter int MAX_LKP_BURST = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       axis_aclk,
  input  logic                       axis_reset,
  input  logic                       lkp_valid,
  output logic                       lkp_ready,
  input  logic [KEY_WIDTH-1:0]       lkp_key,
  input  logic [KEY_WIDTH-1:0]       lkp_mask,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [TCAM_MATCH_ADDR-1:0] wr_addr,
  input  logic [KEY_WIDTH-1:0]       wr_key,
  input  logic [KEY_WIDTH-1:0]       wr_mask,
  output logic                       tcam_req_valid,
  output logic                       tcam_req_wr,
  output logic [TCAM_MATCH_ADDR-1:0] tcam_req_addr,
  output logic [KEY_WIDTH-1:0]       tcam_req_key,
  output logic [KEY_WIDTH-1:0]       tcam_req_mask,
  input  logic                       tcam_busy,
  input  logic                       tcam_end,
  input  logic                       tcam_match,
  input  logic [TCAM_MATCH_ADDR-1:0] tcam_match_addr,
  output logic                       res_valid,
  output logic                       res_match,
  output logic [TCAM_MATCH_ADDR-1:0] res_addr,
  output logic                       res_timeout,
  output logic [15:0]                stat_timeout_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LKP, WAIT_WR} state_t;
  state_t state, state_nxt;
  logic [3:0] burst_cnt;
  logic [7:0] wait_cnt;
  logic grant_lkp, lkp_acc, wr_acc, waiting, expire;
  logic cap_wr;
  logic [TCAM_MATCH_ADDR-1:0] cap_addr;
  logic [KEY_WIDTH-1:0] cap_key, cap_mask;
  assign grant_lkp = lkp_valid && !(wr_valid && burst_cnt == 4'(MAX_LKP_BURST));
  assign lkp_ready = state == IDLE && !tcam_busy && grant_lkp;
  assign wr_ready = state == IDLE && !tcam_busy && !grant_lkp;
  assign lkp_acc = lkp_valid && lkp_ready;
  assign wr_acc = wr_valid && wr_ready;
  assign waiting = state == WAIT_LKP || state == WAIT_WR;
  assign expire = waiting && !tcam_end && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign tcam_req_valid = state == ISSUE;
  assign tcam_req_wr = tcam_req_valid && cap_wr;
  assign tcam_req_addr = tcam_req_valid ? cap_addr : '0;
  assign tcam_req_key = tcam_req_valid ? cap_key : '0;
  assign tcam_req_mask = tcam_req_valid ? cap_mask : '0;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? ((lkp_acc || wr_acc) ? ISSUE : IDLE) :
                state == ISSUE ? (cap_wr ? WAIT_WR : WAIT_LKP) :
                (tcam_end || expire) ? IDLE : state;
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state <= IDLE;
      burst_cnt <= '0;
      wait_cnt <= '0;
      cap_wr <= 1'b0;
      cap_addr <= '0;
      cap_key <= '0;
      cap_mask <= '0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_addr <= '0;
      res_timeout <= 1'b0;
      stat_timeout_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (lkp_acc || wr_acc) begin
        cap_wr <= wr_acc;
        cap_addr <= wr_acc ? wr_addr : '0;
        cap_key <= wr_acc ? wr_key : lkp_key;
        cap_mask <= wr_acc ? wr_mask : lkp_mask;
      end
      burst_cnt <= (wr_acc || (state == IDLE && !wr_valid)) ? '0 : lkp_acc ? burst_cnt + 4'd1 : burst_cnt;
      wait_cnt <= waiting ? wait_cnt + 8'd1 : '0;
      res_valid <= state == WAIT_LKP && (tcam_end || expire);
      res_match <= state == WAIT_LKP && tcam_end && tcam_match;
      res_addr <= (state == WAIT_LKP && tcam_end) ? tcam_match_addr : '0;
      res_timeout <= state == WAIT_LKP && expire;
      if (expire && stat_timeout_cnt != 16'hFFFF) stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_tcam_access_arbiter.sv
// tb_tcam_access_arbiter: directed self-checking bench for tcam_access_arbiter
`timescale 1ns/1ps
module tb_tcam_access_arbiter;
  logic clk, axis_reset;
  logic lkp_valid, lkp_ready, wr_valid, wr_ready;
  logic [31:0] lkp_key, lkp_mask, wr_key, wr_mask;
  logic [9:0] wr_addr;
  logic tcam_req_valid, tcam_req_wr;
  logic [9:0] tcam_req_addr;
  logic [31:0] tcam_req_key, tcam_req_mask;
  logic tcam_busy, tcam_end, tcam_match;
  logic [9:0] tcam_match_addr;
  logic res_valid, res_match, res_timeout;
  logic [9:0] res_addr;
  logic [15:0] stat_timeout_cnt;
  int tests, fails;
  tcam_access_arbiter #(.KEY_WIDTH(32), .TCAM_MATCH_ADDR(10), .MAX_LKP_BURST(4), .TIMEOUT_CYCLES(8)) dut (
    .axis_aclk(clk), .axis_reset(axis_reset),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key), .lkp_mask(lkp_mask),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_key(wr_key), .wr_mask(wr_mask),
    .tcam_req_valid(tcam_req_valid), .tcam_req_wr(tcam_req_wr), .tcam_req_addr(tcam_req_addr),
    .tcam_req_key(tcam_req_key), .tcam_req_mask(tcam_req_mask),
    .tcam_busy(tcam_busy), .tcam_end(tcam_end), .tcam_match(tcam_match), .tcam_match_addr(tcam_match_addr),
    .res_valid(res_valid), .res_match(res_match), .res_addr(res_addr), .res_timeout(res_timeout),
    .stat_timeout_cnt(stat_timeout_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic quiet_inputs();
    lkp_valid = 0;
    lkp_key = 0;
    lkp_mask = 0;
    wr_valid = 0;
    wr_addr = 0;
    wr_key = 0;
    wr_mask = 0;
    tcam_busy = 0;
    tcam_end = 0;
    tcam_match = 0;
    tcam_match_addr = 0;
  endtask
  task automatic test_reset();
    axis_reset = 1;
    quiet_inputs();
    tcam_busy = 1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask} !== 76'd0) begin
      fails++;
      $display("FAIL reset_req: got %h want 0", {tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask});
    end
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt, lkp_ready, wr_ready} !== 31'd0) begin
      fails++;
      $display("FAIL reset_res: got %h want 0", {res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt, lkp_ready, wr_ready});
    end
    @(negedge clk);
    axis_reset = 0;
    tcam_busy = 0;
  endtask
  task automatic test_lookup();
    @(negedge clk);
    lkp_valid = 1;
    lkp_key = 32'h0000_1234;
    lkp_mask = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (lkp_ready !== 1'b1) begin
      fails++;
      $display("FAIL lookup_ready: got %b want 1", lkp_ready);
    end
    @(negedge clk);
    lkp_valid = 0;
    lkp_key = 0;
    lkp_mask = 0;
    #1;
    tests++;
    if ({tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask} !== {1'b1, 1'b0, 10'd0, 32'h0000_1234, 32'hFFFF_FFFF}) begin
      fails++;
      $display("FAIL lookup_cmd: got %b %b %h %h %h want 1 0 000 00001234 ffffffff", tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask);
    end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      tcam_end = i == 4;
      tcam_match = i == 4;
      tcam_match_addr = i == 4 ? 10'd17 : 10'd0;
      #1;
      tests++;
      if ({tcam_req_valid, res_valid} !== 2'b00) begin
        fails++;
        $display("FAIL lookup_wait_t%0d: got req %b res %b want 0 0", i, tcam_req_valid, res_valid);
      end
    end
    @(negedge clk);
    tcam_end = 0;
    tcam_match = 0;
    tcam_match_addr = 0;
    #1;
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout} !== {1'b1, 1'b1, 10'd17, 1'b0}) begin
      fails++;
      $display("FAIL lookup_result: got %b %b %0d %b want 1 1 17 0", res_valid, res_match, res_addr, res_timeout);
    end
    @(negedge clk);
    #1;
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout} !== 13'd0) begin
      fails++;
      $display("FAIL lookup_res_clear: got %b %b %0d %b want 0 0 0 0", res_valid, res_match, res_addr, res_timeout);
    end
  endtask
  task automatic test_write();
    @(negedge clk);
    wr_valid = 1;
    wr_addr = 10'd5;
    wr_key = 32'hAABB_CCDD;
    wr_mask = 32'hFFFF_0000;
    #1;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL write_ready: got %b want 1", wr_ready);
    end
    @(negedge clk);
    wr_addr = 10'd9;
    wr_key = 32'h1111_2222;
    #1;
    tests++;
    if ({tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask} !== {1'b1, 1'b1, 10'd5, 32'hAABB_CCDD, 32'hFFFF_0000}) begin
      fails++;
      $display("FAIL write_cmd: got %b %b %h %h %h want 1 1 005 aabbccdd ffff0000", tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask);
    end
    tests++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_ready_issue: got %b want 0", wr_ready);
    end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      tcam_end = i == 4;
      #1;
      tests++;
      if ({wr_ready, tcam_req_valid, res_valid} !== 3'b000) begin
        fails++;
        $display("FAIL write_wait_t%0d: got ready %b req %b res %b want 0 0 0", i, wr_ready, tcam_req_valid, res_valid);
      end
    end
    @(negedge clk);
    tcam_end = 0;
    wr_valid = 0;
    #1;
    tests++;
    if ({wr_ready, tcam_req_valid, res_valid} !== 3'b100) begin
      fails++;
      $display("FAIL write_done: got ready %b req %b res %b want 1 0 0", wr_ready, tcam_req_valid, res_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL write_no_result: got %b want 0", res_valid);
    end
  endtask
  task automatic test_burst();
    int n = 0;
    int dly = 0;
    logic [9:0] got = '0;
    lkp_key = 32'hCAFE_0000;
    lkp_mask = 32'hFFFF_FFFF;
    wr_addr = 10'h3FF;
    wr_key = 32'h0000_BEEF;
    wr_mask = 32'hFFFF_FFFF;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      lkp_valid = 1;
      wr_valid = 1;
      tcam_end = dly == 1;
      if (dly > 0) dly--;
      #1;
      if (tcam_req_valid) dly = 2;
      if (lkp_valid && lkp_ready) begin
        got = {1'b0, got[9:1]};
        n++;
      end else if (wr_valid && wr_ready) begin
        got = {1'b1, got[9:1]};
        n++;
      end
    end
    tests++;
    if (n != 10 || got !== 10'h210) begin
      fails++;
      $display("FAIL burst_order: got %0d grants pattern %b want 10 grants pattern 1000010000 (bit0 first, 1=W)", n, got);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      lkp_valid = 0;
      wr_valid = 0;
      tcam_end = dly == 1;
      if (dly > 0) dly--;
      #1;
      if (tcam_req_valid) dly = 2;
    end
    @(negedge clk);
    tcam_end = 0;
    #1;
    tests++;
    if ({wr_ready, tcam_req_valid} !== 2'b10) begin
      fails++;
      $display("FAIL burst_drain: got ready %b req %b want 1 0", wr_ready, tcam_req_valid);
    end
  endtask
  task automatic test_busy();
    lkp_key = 32'h5555_AAAA;
    lkp_mask = 32'h0F0F_0F0F;
    wr_addr = 10'd3;
    wr_key = 32'h7777_7777;
    wr_mask = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tcam_busy = 1;
      lkp_valid = 1;
      wr_valid = 1;
      #1;
      tests++;
      if ({lkp_ready, wr_ready} !== 2'b00) begin
        fails++;
        $display("FAIL busy_hold_%0d: got lkp %b wr %b want 0 0", i, lkp_ready, wr_ready);
      end
    end
    @(negedge clk);
    tcam_busy = 0;
    #1;
    tests++;
    if ({lkp_ready, wr_ready} !== 2'b10) begin
      fails++;
      $display("FAIL busy_release: got lkp %b wr %b want 1 0", lkp_ready, wr_ready);
    end
    @(negedge clk);
    lkp_valid = 0;
    wr_valid = 0;
    #1;
    tests++;
    if ({tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask} !== {1'b1, 1'b0, 10'd0, 32'h5555_AAAA, 32'h0F0F_0F0F}) begin
      fails++;
      $display("FAIL busy_first_cmd: got %b %b %h %h %h want 1 0 000 5555aaaa 0f0f0f0f", tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask);
    end
    @(negedge clk);
    @(negedge clk);
    tcam_end = 1;
    @(negedge clk);
    tcam_end = 0;
    #1;
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout} !== {1'b1, 1'b0, 10'd0, 1'b0}) begin
      fails++;
      $display("FAIL busy_result: got %b %b %0d %b want 1 0 0 0", res_valid, res_match, res_addr, res_timeout);
    end
  endtask
  task automatic test_timeout();
    @(negedge clk);
    lkp_valid = 1;
    lkp_key = 32'h0BAD_F00D;
    lkp_mask = 32'hFFFF_FFFF;
    @(negedge clk);
    lkp_valid = 0;
    #1;
    tests++;
    if (tcam_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_cmd: got %b want 1", tcam_req_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if (res_valid !== 1'b0) begin
        fails++;
        $display("FAIL timeout_early_%0d: got res_valid %b want 0", i, res_valid);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout} !== {1'b1, 1'b0, 10'd0, 1'b1}) begin
      fails++;
      $display("FAIL timeout_result: got %b %b %0d %b want 1 0 0 1", res_valid, res_match, res_addr, res_timeout);
    end
    tests++;
    if (stat_timeout_cnt !== 16'd1) begin
      fails++;
      $display("FAIL timeout_stat: got %0d want 1", stat_timeout_cnt);
    end
    @(negedge clk);
    tcam_end = 1;
    tcam_match = 1;
    tcam_match_addr = 10'd99;
    @(negedge clk);
    tcam_end = 0;
    tcam_match = 0;
    tcam_match_addr = 0;
    #1;
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_stray_end: got res_valid %b want 0", res_valid);
    end
    lkp_valid = 1;
    #1;
    tests++;
    if (lkp_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_next_ready: got %b want 1", lkp_ready);
    end
    @(negedge clk);
    lkp_valid = 0;
    @(negedge clk);
    @(negedge clk);
    tcam_end = 1;
    tcam_match = 1;
    tcam_match_addr = 10'h3FF;
    @(negedge clk);
    tcam_end = 0;
    tcam_match = 0;
    tcam_match_addr = 0;
    #1;
    tests++;
    if ({res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt} !== {1'b1, 1'b1, 10'h3FF, 1'b0, 16'd1}) begin
      fails++;
      $display("FAIL timeout_next_lookup: got %b %b %h %b stat %0d want 1 1 3ff 0 stat 1", res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt);
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    lkp_valid = 1;
    lkp_key = 32'h1357_9BDF;
    lkp_mask = 32'hFFFF_FFFF;
    @(negedge clk);
    lkp_valid = 0;
    @(negedge clk);
    axis_reset = 1;
    @(negedge clk);
    axis_reset = 0;
    tcam_end = 1;
    tcam_match = 1;
    tcam_match_addr = 10'd7;
    #1;
    tests++;
    if ({tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask, res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt, lkp_ready} !== 106'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h want 0", {tcam_req_valid, tcam_req_wr, tcam_req_addr, tcam_req_key, tcam_req_mask, res_valid, res_match, res_addr, res_timeout, stat_timeout_cnt, lkp_ready});
    end
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_idle: got wr_ready %b want 1", wr_ready);
    end
    @(negedge clk);
    tcam_end = 0;
    tcam_match = 0;
    tcam_match_addr = 0;
    #1;
    tests++;
    if ({res_valid, tcam_req_valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_dropped_end: got res %b req %b want 0 0", res_valid, tcam_req_valid);
    end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    axis_reset = 1;
    quiet_inputs();
    test_reset();
    test_lookup();
    test_write();
    test_burst();
    test_busy();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
